// File: rtl/master_port_if.sv
// Parallel request side and bit-serial bus side of the master port, grouped as one bundle.
// The master modport is the port block's view; the slave modport is the core/bus view.
interface master_port_if #(
  parameter int unsigned AddrW = 16,
  parameter int unsigned DataW = 8
);
  logic             m_start;
  logic             m_mode;
  logic [AddrW-1:0] m_addr;
  logic [DataW-1:0] m_wr_data;
  logic [DataW-1:0] m_rd_data;
  logic             m_wr_en;
  logic             mode;
  logic             wr_bus;
  logic             master_valid;
  logic             slave_ready;
  logic             rd_bus;
  logic             slave_valid;
  logic             master_ready;

  modport master (
    input  m_start, m_mode, m_addr, m_wr_data, slave_ready, rd_bus, slave_valid,
    output m_rd_data, m_wr_en, mode, wr_bus, master_valid, master_ready
  );

  modport slave (
    output m_start, m_mode, m_addr, m_wr_data, slave_ready, rd_bus, slave_valid,
    input  m_rd_data, m_wr_en, mode, wr_bus, master_valid, master_ready
  );
endinterface

// File: rtl/master_port.sv
// Bit-serial bus master: shifts out address (and write data) LSB first, or assembles an
// LSB-first read byte from the slave, using valid/ready handshakes on each bit.
module master_port #(
  parameter int unsigned AddrW = 16,
  parameter int unsigned DataW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  master_port_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRdata} state_e;

  localparam logic [4:0] LastAddr = 5'(AddrW - 1);
  localparam logic [4:0] LastData = 5'(DataW - 1);

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic [DataW-1:0] rx_q, rx_d;
  logic [DataW-1:0] rd_data_q, rd_data_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             wr_en_q, wr_en_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    wr_en_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.m_start) begin
          addr_d  = bus_io.m_addr;
          data_d  = bus_io.m_wr_data;
          mode_d  = bus_io.m_mode;
          cnt_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (bus_io.slave_ready) begin
          addr_d = addr_q >> 1;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LastAddr) begin
            cnt_d   = '0;
            state_d = mode_q ? StWdata : StRdata;
          end
        end
      end
      StWdata: begin
        if (bus_io.slave_ready) begin
          data_d = data_q >> 1;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LastData) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      StRdata: begin
        if (bus_io.slave_valid) begin
          // LSB-first: each new bit enters at the top and earlier bits move down
          rx_d  = {bus_io.rd_bus, rx_q[DataW-1:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LastData) begin
            cnt_d     = '0;
            rd_data_d = rx_d;
            wr_en_d   = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.master_valid = (state_q == StAddr) || (state_q == StWdata);
  assign bus_io.master_ready = (state_q == StRdata);
  assign bus_io.wr_bus       = (state_q == StAddr)  ? addr_q[0] :
                               (state_q == StWdata) ? data_q[0] : 1'b0;
  assign bus_io.mode         = mode_q;
  assign bus_io.m_rd_data    = rd_data_q;
  assign bus_io.m_wr_en      = wr_en_q;

endmodule

// File: tb/tb_master_port.sv
// Self-checking bench for master_port: table of transactions (directed + random) checked
// against a transaction-level model, plus hand sequences for reset, chaining and mode hold.
module tb_master_port;
  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  master_port_if #(.AddrW(AddrW), .DataW(DataW)) bus ();

  master_port #(.AddrW(AddrW), .DataW(DataW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus_io (bus)
  );

  typedef struct {
    bit        mode;
    bit [15:0] addr;
    bit [7:0]  wdata;
    bit [7:0]  rdbyte;
    int        stall;     // 0: none, 1: alternate, 2: random
    bit        poke;      // wiggle request inputs while busy
    bit [23:0] exp_word;  // serial bits expected on wr_bus, LSB first
    int        exp_n;
    bit [7:0]  exp_rd;
  } vec_t;

  int        checks = 0;
  int        failures = 0;
  logic [7:0] last_rd = 8'h00;
  bit        chain_next = 1'b0;
  vec_t      next_v;
  vec_t      vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: what should appear on the bus and in m_rd_data
  function automatic vec_t mk(bit mode, bit [15:0] addr, bit [7:0] wdata, bit [7:0] rdbyte,
                              int stall, bit poke);
    vec_t v;
    v.mode     = mode;
    v.addr     = addr;
    v.wdata    = wdata;
    v.rdbyte   = rdbyte;
    v.stall    = stall;
    v.poke     = poke;
    v.exp_n    = mode ? 24 : 16;
    v.exp_word = mode ? {wdata, addr} : {8'h00, addr};
    v.exp_rd   = rdbyte;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    bus.m_mode    = v.mode;
    bus.m_addr    = v.addr;
    bus.m_wr_data = v.wdata;
    bus.m_start   = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input bit pre_started);
    logic [23:0] word = '0;
    int n = 0, vcyc = 0, mr_cyc = 0, rd_acc = 0;
    int mode_err = 0, hold_err = 0, busy_wr_en = 0;
    bit stalled = 0, done = 0, hs;
    logic held = 1'b0, pulse = 1'b0;
    logic [7:0] rd_seen = '0;
    if (!pre_started) begin
      @(negedge clk);
      drive_req(v);
    end
    @(negedge clk);
    bus.m_start = 1'b0;
    chk("mode_latched", 32'(bus.mode), 32'(v.mode));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.master_valid && !bus.master_ready) begin
        done    = 1;
        pulse   = bus.m_wr_en;
        rd_seen = bus.m_rd_data;
        bus.m_start = 1'b0;
        if (chain_next) begin
          drive_req(next_v);
          chain_next = 1'b0;
        end
        break;
      end
      if (bus.m_wr_en) busy_wr_en++;
      if (bus.mode !== v.mode) mode_err++;
      if (stalled && bus.master_valid && bus.wr_bus !== held) hold_err++;
      case (v.stall)
        1:       hs = (cyc % 2) == 0;
        2:       hs = 1'($urandom_range(0, 1));
        default: hs = 1'b1;
      endcase
      bus.slave_ready = hs;
      bus.slave_valid = hs;
      bus.rd_bus = (rd_acc < 8) ? v.rdbyte[rd_acc] : 1'b0;
      if (v.poke) begin
        bus.m_start   = 1'($urandom_range(0, 1));
        bus.m_mode    = ~v.mode;
        bus.m_addr    = 16'($urandom);
        bus.m_wr_data = 8'($urandom);
      end
      if (bus.master_valid) begin
        vcyc++;
        if (bus.slave_ready) begin
          if (n < 24) word[n] = bus.wr_bus;
          n++;
        end
      end
      stalled = bus.master_valid && !bus.slave_ready;
      held    = bus.wr_bus;
      if (bus.master_ready) begin
        mr_cyc++;
        if (bus.slave_valid) rd_acc++;
      end
      @(negedge clk);
    end
    chk("txn_done", 32'(done), 32'd1);
    chk("bit_count", 32'(n), 32'(v.exp_n));
    chk("bit_stream", 32'(word), 32'(v.exp_word));
    chk("mode_during", 32'(mode_err), 32'd0);
    chk("wr_en_busy", 32'(busy_wr_en), 32'd0);
    if (v.stall != 0) chk("bit_hold", 32'(hold_err), 32'd0);
    if (v.stall == 0) chk("valid_cycles", 32'(vcyc), 32'(v.exp_n));
    if (!v.mode) begin
      last_rd = v.exp_rd;
      chk("rd_bits", 32'(rd_acc), 32'd8);
      if (v.stall == 0) chk("ready_cycles", 32'(mr_cyc), 32'd8);
    end else begin
      chk("ready_cycles_wr", 32'(mr_cyc), 32'd0);
    end
    chk("wr_en_pulse", 32'(pulse), 32'(!v.mode));
    chk("rd_data", 32'(rd_seen), 32'(last_rd));
  endtask

  initial begin
    int idle_mv;
    bus.m_start = 0; bus.m_mode = 0; bus.m_addr = '0; bus.m_wr_data = '0;
    bus.slave_ready = 0; bus.rd_bus = 0; bus.slave_valid = 0;

    // Reset state
    #1;
    chk("reset_outs", {26'd0, bus.m_wr_en, bus.mode, bus.wr_bus, bus.master_valid,
                       bus.master_ready, 1'b0}, 32'd0);
    chk("reset_rd_data", 32'(bus.m_rd_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle_mv = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.master_valid || bus.master_ready) idle_mv++;
    end
    chk("idle_stays", 32'(idle_mv), 32'd0);

    // Directed rows with literal expectations, then random rows from the model
    vecs.push_back('{1'b1, 16'hABCD, 8'hD3, 8'h00, 0, 1'b0, 24'hD3ABCD, 24, 8'h00});
    vecs.push_back('{1'b0, 16'hABCD, 8'h00, 8'h01, 0, 1'b0, 24'h00ABCD, 16, 8'h01});
    vecs.push_back('{1'b1, 16'hABCD, 8'hD3, 8'h00, 1, 1'b0, 24'hD3ABCD, 24, 8'h00});
    vecs.push_back('{1'b0, 16'hABCD, 8'h00, 8'h01, 1, 1'b0, 24'h00ABCD, 16, 8'h01});
    vecs.push_back('{1'b0, 16'h1234, 8'h00, 8'hDB, 0, 1'b1, 24'h001234, 16, 8'hDB});
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
                        int'($urandom_range(0, 2)), 1'($urandom_range(0, 1))));
    foreach (vecs[i]) run_txn(vecs[i], 1'b0);

    // Back-to-back: new request issued in the m_wr_en cycle of a read
    chain_next = 1'b1;
    next_v = mk(1'b1, 16'h5AA5, 8'h3C, 8'h00, 0, 1'b0);
    run_txn(mk(1'b0, 16'h0F0F, 8'h00, 8'hA6, 0, 1'b0), 1'b0);
    run_txn(next_v, 1'b1);

    // mode holds after completion
    repeat (3) @(negedge clk);
    chk("mode_holds", 32'(bus.mode), 32'd1);
    chk("idle_after", 32'(bus.master_valid), 32'd0);

    // Async reset during the address phase
    @(negedge clk);
    drive_req(mk(1'b0, 16'hABCD, 8'h00, 8'h00, 0, 1'b0));
    @(negedge clk);
    bus.m_start = 1'b0;
    bus.slave_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("addr_phase", 32'(bus.master_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_outs", {26'd0, bus.m_wr_en, bus.mode, bus.wr_bus, bus.master_valid,
                         bus.master_ready, 1'b0}, 32'd0);
    chk("rst_mid_rd_data", 32'(bus.m_rd_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_idle", 32'(bus.master_valid | bus.master_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
